// File: rtl/map_serializer_if.sv
// map_serializer_if
//   Bundles the snapshot request, the cell stream and the status signals of
//   the map serializer so they travel as one port.
//
//   Parameters
//     map_width   cells per row
//     map_height  rows per map
//
//   Signals
//     start       request to snapshot state_in and stream it
//     state_in    flattened map, bit y*map_width+x is cell (x,y)
//     busy        serializer is streaming or finishing a frame
//     cell_valid  a cell is being presented
//     cell_ready  consumer accepts the presented cell
//     cell_data   alive bit of the presented cell
//     cell_x      column of the presented cell
//     cell_y      row of the presented cell
//     frame_done  one-cycle pulse after the last cell is accepted
//
//   Modports
//     master  the serializer side
//     slave   the requester / consumer side
interface map_serializer_if #(
    parameter int map_width  = 8,
    parameter int map_height = 8
);
    localparam int XW = (map_width  > 1) ? $clog2(map_width)  : 1;
    localparam int YW = (map_height > 1) ? $clog2(map_height) : 1;

    logic                          start;
    logic [map_width*map_height-1:0] state_in;
    logic                          busy;
    logic                          cell_valid;
    logic                          cell_ready;
    logic                          cell_data;
    logic [XW-1:0]                 cell_x;
    logic [YW-1:0]                 cell_y;
    logic                          frame_done;

    modport master (
        input  start,
        input  state_in,
        input  cell_ready,
        output busy,
        output cell_valid,
        output cell_data,
        output cell_x,
        output cell_y,
        output frame_done
    );

    modport slave (
        output start,
        output state_in,
        output cell_ready,
        input  busy,
        input  cell_valid,
        input  cell_data,
        input  cell_x,
        input  cell_y,
        input  frame_done
    );
endinterface

// File: rtl/map_serializer.sv
// map_serializer
//   Captures a flattened cell map on start and streams it one cell per
//   accepted handshake, row by row starting at (0,0). A one-cycle
//   frame_done pulse follows the last accepted cell. All outputs are
//   registered; reset is synchronous and active-high.
//
//   Parameters
//     map_width   cells per row (>= 1)
//     map_height  rows per map (>= 1)
//
//   Ports
//     clock   rising-edge clock for all state
//     reset   synchronous active-high reset
//     bus     map_serializer_if master modport (start/state_in request,
//             valid/ready cell stream with x/y/data, busy, frame_done)
module map_serializer #(
    parameter int map_width  = 8,
    parameter int map_height = 8
) (
    input  logic             clock,
    input  logic             reset,
    map_serializer_if.master bus
);
    localparam int XW    = (map_width  > 1) ? $clog2(map_width)  : 1;
    localparam int YW    = (map_height > 1) ? $clog2(map_height) : 1;
    localparam int CELLS = map_width * map_height;
    localparam int CW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(map_width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(map_height - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CELLS-1:0] snapshot, snapshot_next;
    logic [XW-1:0]    x_q, x_next;
    logic [YW-1:0]    y_q, y_next;
    logic             valid_q, valid_next;
    logic             data_q, data_next;
    logic             done_q, done_next;
    logic             busy_q, busy_next;
    logic             transfer;
    logic [CW-1:0]    idx_next;

    assign transfer = (state == SEND) && valid_q && bus.cell_ready;

    // Next-state and next-output logic. The presented position doubles as
    // the scan counter, so x_q/y_q are both the cursor and cell_x/cell_y.
    // The cell bit is looked up from the position being moved to, which
    // keeps cell_data aligned with cell_x/cell_y while staying registered.
    // The index arithmetic wraps at CW bits, which is harmless because every
    // legal position indexes below CELLS.
    always_comb begin
        state_next    = state;
        snapshot_next = snapshot;
        x_next        = x_q;
        y_next        = y_q;
        valid_next    = valid_q;
        data_next     = data_q;
        done_next     = 1'b0;
        busy_next     = busy_q;
        idx_next      = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    snapshot_next = bus.state_in;
                    x_next        = '0;
                    y_next        = '0;
                    valid_next    = 1'b1;
                    busy_next     = 1'b1;
                    state_next    = SEND;
                end
            end
            SEND: begin
                if (transfer) begin
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else if (x_q == X_LAST) begin
                        x_next = '0;
                        y_next = y_q + YW'(1);
                    end else begin
                        x_next = x_q + XW'(1);
                    end
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                valid_next = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase

        idx_next = CW'(y_next) * CW'(map_width) + CW'(x_next);
        if (state_next == SEND) begin
            data_next = snapshot_next[idx_next];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            snapshot <= '0;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            data_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            snapshot <= snapshot_next;
            x_q      <= x_next;
            y_q      <= y_next;
            valid_q  <= valid_next;
            data_q   <= data_next;
            done_q   <= done_next;
            busy_q   <= busy_next;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.cell_valid = valid_q;
    assign bus.cell_data  = data_q;
    assign bus.cell_x     = x_q;
    assign bus.cell_y     = y_q;
    assign bus.frame_done = done_q;
endmodule

// File: doc/map_serializer.md
MAP_SERIALIZER -- requirements
Module: map_serializer

Interface
REQ-001 Parameter map_width, default 8, cells per row (>=1).
REQ-002 Parameter map_height, default 8, rows per map (>=1).
REQ-003 Define XW = max(1, clog2(map_width)) and YW = max(1, clog2(map_height)).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to snapshot state_in and stream it; sampled only in IDLE.
REQ-008 state_in  input  map_width*map_height  flattened map; bit i = cell (x,y) with i = y*map_width + x.
REQ-009 busy  output  1  high in SEND and DONE.
REQ-010 cell_valid  output  1  current cell presented.
REQ-011 cell_ready  input  1  downstream accepts the presented cell.
REQ-012 cell_data  output  1  alive bit of presented cell.
REQ-013 cell_x  output  XW  column of presented cell.
REQ-014 cell_y  output  YW  row of presented cell.
REQ-015 frame_done  output  1  single-cycle pulse after the last cell transfers.

Function
REQ-016 FSM states SHALL be IDLE, SEND and DONE, with all outputs registered.
REQ-017 IDLE & start at edge N: capture state_in into an internal snapshot, set x=0 and y=0, enter SEND, and drive cell_valid=1 from cycle N+1.
REQ-018 In SEND: cell_data = snapshot[y*map_width+x], cell_x = x, cell_y = y.
REQ-019 Transfer occurs on an edge where cell_valid & cell_ready.
REQ-020 While cell_valid=1 & cell_ready=0, cell_data, cell_x and cell_y SHALL hold stable and cell_valid SHALL stay high; valid SHALL never drop without a transfer, except on reset.
REQ-021 On transfer with x<map_width-1: x increments and y holds.
REQ-022 On transfer with x=map_width-1 and y<map_height-1: x wraps to 0 and y increments.
REQ-023 On transfer of the last cell (x=map_width-1, y=map_height-1):
- cell_valid deasserts at the next edge;
- the FSM enters DONE with frame_done=1 for exactly one cycle;
- the FSM then returns to IDLE.
REQ-024 Back-to-back transfers (cell_ready held high) SHALL deliver one cell per cycle; a full frame takes map_width*map_height cycles in SEND.
REQ-025 start in SEND or DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 state_in changes after capture SHALL NOT affect the streamed frame.
REQ-027 For a 1x1 map, the single transfer SHALL go directly to DONE.
REQ-028 cell_ready while cell_valid=0 SHALL have no effect.
REQ-029 In IDLE and DONE: cell_valid=0, and cell_data, cell_x and cell_y hold their last values (don't-care to consumers).

Reset
REQ-030 reset=1 at an edge SHALL force, in every state:
- IDLE;
- busy=0, cell_valid=0, frame_done=0;
- cell_x=0, cell_y=0, cell_data=0;
- snapshot=0.
REQ-031 Reset mid-frame SHALL abort the frame without a frame_done pulse.
REQ-032 If reset and start are both high at an edge, reset SHALL win.
REQ-033 The first start after reset deasserts SHALL be honoured normally.

Verification
REQ-034 Defaults, state_in=64'h0000_0000_0000_0081, start pulse, cell_ready=1 -> 64 consecutive valid cycles, and:
- cell_data=1 only at (0,0) and (7,0);
- frame_done pulses 1 cycle after (7,7);
- busy is high for 65 cycles.
REQ-035 Backpressure: cell_ready low for 3 cycles while (2,0) is presented -> (2,0) holds for 4 cycles, with no skipped or duplicated cells.
REQ-036 Toggle state_in to all-ones one cycle after start -> streamed data still matches the captured value.
REQ-037 Assert start during SEND at cell (3,1) -> no restart, one frame_done only.
REQ-038 Assert reset at cell (5,4) -> next cycle cell_valid=0, busy=0, cell_x=0, cell_y=0, no frame_done; a new start then streams from (0,0).
REQ-039 Parameters map_width=3, map_height=2, state_in=6'b100110, cell_ready randomly toggled -> sequence 0,1,1,0,0,1 at (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
